// File: rtl/pll_lock_supervisor.sv
// Sequenced bring-up from raw PLL lock: debounced lock qualification, timed PHY
// reset pulse, PHY settle interval, then system reset release. Also counts lock losses.
module pll_lock_supervisor #(
   parameter int LOCK_STABLE_CYCLES = 1250,
   parameter int PHY_RST_CYCLES     = 1250000,
   parameter int PHY_SETTLE_CYCLES  = 625000,
   parameter int LOSS_COUNT_WIDTH   = 8,
   parameter int BLINK_BIT          = 23
) (
   input  logic                        clock,
   input  logic                        resetn,
   input  logic                        locked_async,
   output logic                        phy_resetn,
   output logic                        sys_resetn,
   output logic                        ready,
   output logic [LOSS_COUNT_WIDTH-1:0] loss_count,
   output logic                        led
);

   localparam int MAX_AB     = (LOCK_STABLE_CYCLES > PHY_RST_CYCLES) ? LOCK_STABLE_CYCLES : PHY_RST_CYCLES;
   localparam int MAX_CYCLES = (MAX_AB > PHY_SETTLE_CYCLES) ? MAX_AB : PHY_SETTLE_CYCLES;
   localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PHY_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(PHY_SETTLE_CYCLES - 1);

   localparam logic [2:0] S_WAIT_LOCK  = 3'd0;
   localparam logic [2:0] S_STABLE     = 3'd1;
   localparam logic [2:0] S_PHY_RST    = 3'd2;
   localparam logic [2:0] S_PHY_SETTLE = 3'd3;
   localparam logic [2:0] S_RUN        = 3'd4;

   logic [1:0]         sync_q;
   logic               lock_s;
   logic [2:0]         state_q;
   logic [2:0]         state_d;
   logic [CNT_W-1:0]   dwell_q;
   logic [BLINK_BIT:0] blink_q;
   logic [BLINK_BIT:0] blink_d;
   logic               loss_event;
   logic               led_d;

   assign lock_s  = sync_q[1];
   assign blink_d = blink_q + 1'b1;

   // NOTE: every signal assigned in a combinational block gets a default first,
   // otherwise a path that skips the assignment infers a latch.
   always_comb begin
      state_d    = state_q;
      loss_event = 1'b0;
      case (state_q)
         S_WAIT_LOCK: begin
            if (lock_s) state_d = S_STABLE;
         end
         S_STABLE: begin
            if (!lock_s)                    state_d = S_WAIT_LOCK;
            else if (dwell_q == STABLE_LAST) state_d = S_PHY_RST;
         end
         S_PHY_RST: begin
            if (!lock_s) begin
               state_d    = S_WAIT_LOCK;
               loss_event = 1'b1;
            end else if (dwell_q == RST_LAST) begin
               state_d = S_PHY_SETTLE;
            end
         end
         S_PHY_SETTLE: begin
            // Lock loss wins over dwell expiry on the same cycle.
            if (!lock_s) begin
               state_d    = S_WAIT_LOCK;
               loss_event = 1'b1;
            end else if (dwell_q == SETTLE_LAST) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (!lock_s) begin
               state_d    = S_WAIT_LOCK;
               loss_event = 1'b1;
            end
         end
         default: state_d = S_WAIT_LOCK;
      endcase
   end

   always_comb begin
      led_d = 1'b1;
      case (state_d)
         S_PHY_RST, S_PHY_SETTLE: led_d = ~blink_d[BLINK_BIT];
         S_RUN:                   led_d = 1'b0;
         default:                 led_d = 1'b1;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sync_q     <= '0;
         state_q    <= S_WAIT_LOCK;
         dwell_q    <= '0;
         blink_q    <= '0;
         loss_count <= '0;
         phy_resetn <= 1'b0;
         sys_resetn <= 1'b0;
         ready      <= 1'b0;
         led        <= 1'b1;
      end else begin
         sync_q  <= {sync_q[0], locked_async};
         state_q <= state_d;
         dwell_q <= (state_d != state_q) ? '0 : dwell_q + 1'b1;
         blink_q <= blink_d;
         if (loss_event && (loss_count != '1)) loss_count <= loss_count + 1'b1;
         // Outputs decode the next state so they move on the same edge as the state.
         phy_resetn <= (state_d == S_PHY_SETTLE) || (state_d == S_RUN);
         sys_resetn <= (state_d == S_RUN);
         ready      <= (state_d == S_RUN);
         led        <= led_d;
      end
   end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: directed edge-exact table, hand-written
// corner sequences, and randomized lock activity against a phase/remaining-time model.
module tb_pll_lock_supervisor;

   localparam int LS = 4;
   localparam int PR = 8;
   localparam int PS = 6;
   localparam int BB = 2;
   localparam int LW = 2;
   localparam int LOSS_MAX = (1 << LW) - 1;

   logic          clock = 1'b0;
   logic          resetn = 1'b1;
   logic          locked_async = 1'b0;
   logic          phy_resetn;
   logic          sys_resetn;
   logic          ready;
   logic [LW-1:0] loss_count;
   logic          led;

   int checks = 0;
   int failures = 0;

   pll_lock_supervisor #(
      .LOCK_STABLE_CYCLES (LS),
      .PHY_RST_CYCLES     (PR),
      .PHY_SETTLE_CYCLES  (PS),
      .LOSS_COUNT_WIDTH   (LW),
      .BLINK_BIT          (BB)
   ) dut (
      .clock        (clock),
      .resetn       (resetn),
      .locked_async (locked_async),
      .phy_resetn   (phy_resetn),
      .sys_resetn   (sys_resetn),
      .ready        (ready),
      .loss_count   (loss_count),
      .led          (led)
   );

   always #5 clock = ~clock;

   // Reference model: bring-up phase plus cycles remaining in it.
   typedef enum int {M_WAIT, M_STABLE, M_RST, M_SETTLE, M_RUN} mphase_t;
   mphase_t m_phase;
   int      m_left;
   int      m_loss;
   int      m_blink;
   logic    m_s1;
   logic    m_s2;

   function automatic void model_reset();
      m_phase = M_WAIT;
      m_left  = 0;
      m_loss  = 0;
      m_blink = 0;
      m_s1    = 1'b0;
      m_s2    = 1'b0;
   endfunction

   function automatic void model_lose();
      m_phase = M_WAIT;
      if (m_loss < LOSS_MAX) m_loss = m_loss + 1;
   endfunction

   function automatic void model_edge(input logic lin);
      logic ls;
      ls = m_s2;
      m_blink = (m_blink + 1) % (1 << (BB + 1));
      case (m_phase)
         M_WAIT: if (ls) begin m_phase = M_STABLE; m_left = LS; end
         M_STABLE: begin
            if (!ls) m_phase = M_WAIT;
            else begin
               m_left = m_left - 1;
               if (m_left == 0) begin m_phase = M_RST; m_left = PR; end
            end
         end
         M_RST: begin
            if (!ls) model_lose();
            else begin
               m_left = m_left - 1;
               if (m_left == 0) begin m_phase = M_SETTLE; m_left = PS; end
            end
         end
         M_SETTLE: begin
            if (!ls) model_lose();
            else begin
               m_left = m_left - 1;
               if (m_left == 0) m_phase = M_RUN;
            end
         end
         default: if (!ls) model_lose();
      endcase
      m_s2 = m_s1;
      m_s1 = lin;
   endfunction

   function automatic logic [5:0] model_outputs();
      logic e_phy, e_sys, e_led;
      e_phy = (m_phase == M_SETTLE) || (m_phase == M_RUN);
      e_sys = (m_phase == M_RUN);
      if (m_phase == M_RUN)                              e_led = 1'b0;
      else if (m_phase == M_RST || m_phase == M_SETTLE) e_led = ((m_blink >> BB) & 1) == 0;
      else                                               e_led = 1'b1;
      return {e_phy, e_sys, e_sys, e_led, LW'(m_loss)};
   endfunction

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // One clock edge; compares every output against the model afterwards.
   task automatic tick();
      logic lin;
      lin = locked_async;
      @(posedge clock);
      model_edge(lin);
      #1;
      check("model_outputs", {26'd0, phy_resetn, sys_resetn, ready, led, loss_count},
            {26'd0, model_outputs()});
   endtask

   task automatic do_reset();
      resetn       = 1'b0;
      locked_async = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_phy",   phy_resetn, 1'b0);
      check("rst_sys",   sys_resetn, 1'b0);
      check("rst_ready", ready,      1'b0);
      check("rst_loss",  loss_count, '0);
      check("rst_led",   led,        1'b1);
      resetn = 1'b1;
      model_reset();
   endtask

   typedef struct {
      logic          lock;
      int            edges;
      logic          phy;
      logic          sys;
      logic          rdy;
      logic          led_care;
      logic          led;
      logic [LW-1:0] loss;
   } vec_t;

   vec_t vecs[13];

   initial begin
      // Clean bring-up from edge 0, then a lock loss in RUN and a full re-lock.
      vecs[0]  = '{1'b1,  2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0}; // after edge 1: WAIT_LOCK
      vecs[1]  = '{1'b1,  4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0}; // after edge 5: STABLE
      vecs[2]  = '{1'b1,  8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0}; // after edge 13: PHY_RST
      vecs[3]  = '{1'b1,  1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0}; // edge 14: phy_resetn rises
      vecs[4]  = '{1'b1,  5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0}; // edge 19: still settling
      vecs[5]  = '{1'b1,  1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0}; // edge 20: RUN
      vecs[6]  = '{1'b1, 10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0};
      vecs[7]  = '{1'b0,  2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0}; // lock low, not yet seen
      vecs[8]  = '{1'b0,  1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1}; // 2 edges after sampling
      vecs[9]  = '{1'b1, 14, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
      vecs[10] = '{1'b1,  1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
      vecs[11] = '{1'b1,  5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
      vecs[12] = '{1'b1,  1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1};

      model_reset();
      #2;
      do_reset();

      foreach (vecs[i]) begin
         locked_async = vecs[i].lock;
         repeat (vecs[i].edges) tick();
         check($sformatf("vec%0d_phy", i),   phy_resetn, vecs[i].phy);
         check($sformatf("vec%0d_sys", i),   sys_resetn, vecs[i].sys);
         check($sformatf("vec%0d_ready", i), ready,      vecs[i].rdy);
         check($sformatf("vec%0d_loss", i),  loss_count, vecs[i].loss);
         if (vecs[i].led_care) check($sformatf("vec%0d_led", i), led, vecs[i].led);
      end

      // Async reset in RUN: outputs must drop without a clock edge.
      #3;
      resetn = 1'b0;
      #1;
      check("arst_phy",   phy_resetn, 1'b0);
      check("arst_sys",   sys_resetn, 1'b0);
      check("arst_ready", ready,      1'b0);
      check("arst_loss",  loss_count, '0);
      check("arst_led",   led,        1'b1);
      @(posedge clock);
      #1;
      resetn = 1'b1;
      model_reset();

      // Early glitch during STABLE: no loss count, full STABLE count restarts.
      do_reset();
      locked_async = 1'b1;
      repeat (4) tick();
      locked_async = 1'b0;
      repeat (3) tick();
      check("glitch_loss", loss_count, '0);
      locked_async = 1'b1;
      for (int i = 0; i < 14; i++) begin
         tick();
         check("glitch_phy_low", phy_resetn, 1'b0);
      end
      tick();
      check("glitch_phy_rise", phy_resetn, 1'b1);
      check("glitch_loss_end", loss_count, '0);

      // Repeated loss in PHY_SETTLE: counter saturates.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         locked_async = 1'b1;
         repeat (16) tick();
         check("sat_in_settle", {phy_resetn, ready}, 2'b10);
         locked_async = 1'b0;
         repeat (3) tick();
         check($sformatf("sat_loss%0d", i), loss_count, (i < LOSS_MAX) ? i + 1 : LOSS_MAX);
      end

      // Lock loss seen on the final PHY_SETTLE dwell cycle: never reaches RUN.
      do_reset();
      locked_async = 1'b1;
      repeat (18) tick();
      locked_async = 1'b0;
      repeat (2) tick();
      check("simul_settle", {phy_resetn, ready}, 2'b10);
      tick();
      check("simul_wait",  {phy_resetn, sys_resetn, ready}, 3'b000);
      check("simul_loss",  loss_count, 2'd1);
      repeat (5) tick();
      check("simul_ready", ready, 1'b0);

      // Randomized lock activity, every edge compared against the model.
      do_reset();
      for (int n = 0; n < 3000; ) begin
         int len;
         locked_async = ($urandom_range(0, 3) != 0);
         len = locked_async ? $urandom_range(1, 40) : $urandom_range(1, 4);
         repeat (len) tick();
         n += len;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Consumes the raw EHXPLLL `LOCK` output and turns it into a sequenced bring-up: a debounced lock qualification, a timed PHY reset pulse, a PHY settle interval, then release of the system reset. It sits between the PLL and the rest of the board logic, in the PLL output clock domain. It replaces tying `phy_resetn` high and gating logic directly on raw `locked`. It also counts lock-loss events and drives the onboard LED with bring-up status.

## Interface
Parameters:
- `LOCK_STABLE_CYCLES`, default 1250: consecutive synchronized-lock cycles required before the PHY reset starts (10 µs at 125 MHz). Must be ≥1.
- `PHY_RST_CYCLES`, default 1250000: PHY reset assertion time in the PHY_RST state (10 ms). Must be ≥1.
- `PHY_SETTLE_CYCLES`, default 625000: wait after PHY reset release before the system reset is released (5 ms). Must be ≥1.
- `LOSS_COUNT_WIDTH`, default 8: width of the lock-loss counter.
- `BLINK_BIT`, default 23: free-running counter bit used for the LED blink.

Ports:
- `clock`, input, 1: PLL output clock, 125 MHz. Single clock domain.
- `resetn`, input, 1: asynchronous, active-low reset.
- `locked_async`, input, 1: raw PLL `LOCK`. Asynchronous to `clock`.
- `phy_resetn`, output, 1: PHY reset, active low.
- `sys_resetn`, output, 1: system reset for downstream logic, active low.
- `ready`, output, 1: high only in the RUN state.
- `loss_count`, output, `LOSS_COUNT_WIDTH`: count of lock losses, saturating.
- `led`, output, 1: onboard LED, active low.

## Operation
- **Synchronizer:** `locked_async` passes through a 2-flop synchronizer, producing `lock_s`. Both flops reset to 0. No other logic uses `locked_async`.
- **State register:** holds one of WAIT_LOCK, STABLE, PHY_RST, PHY_SETTLE, RUN.
- **Dwell counter:** a single counter shared by all states. Its width is clog2 of the largest cycle parameter. It clears on every state change.
- **WAIT_LOCK:** go to STABLE when `lock_s` is 1.
- **STABLE:**
  - If `lock_s` is 0, go to WAIT_LOCK. `loss_count` does not increment.
  - Otherwise, when the counter equals `LOCK_STABLE_CYCLES-1`, go to PHY_RST.
- **PHY_RST:** go to PHY_SETTLE when the counter equals `PHY_RST_CYCLES-1`.
- **PHY_SETTLE:** go to RUN when the counter equals `PHY_SETTLE_CYCLES-1`.
- **Lock loss in PHY_RST, PHY_SETTLE or RUN:** if `lock_s` is 0, go to WAIT_LOCK and increment `loss_count` by 1. The increment saturates at all-ones and never wraps. Lock loss takes priority over a dwell-expiry transition in the same cycle.
- **Outputs** are registered and decoded from the next state, so they change on the same edge as the state:
  - `phy_resetn` is 0 in WAIT_LOCK, STABLE and PHY_RST, and 1 in PHY_SETTLE and RUN.
  - `sys_resetn` and `ready` are 1 only in RUN.
  - `led` is 1 (off) in WAIT_LOCK and STABLE.
  - `led` is the inverse of blink-counter bit `BLINK_BIT` in PHY_RST and PHY_SETTLE.
  - `led` is 0 (on) in RUN.
- **Blink counter:** free-running and `BLINK_BIT+1` bits wide. It resets to 0.
- **Re-lock:** after any return to WAIT_LOCK, the full sequence repeats. The PHY is always re-reset.

## Timing
- **Reset values (while `resetn` is 0):**
  - State is WAIT_LOCK and all counters are 0.
  - `phy_resetn`=0, `sys_resetn`=0, `ready`=0, `loss_count`=0, `led`=1.
  - Reset asserted mid-sequence forces these values immediately, with no clock edge needed.
- **Lock-rise latency:** if `locked_async` rises before edge k, `lock_s` is 1 after edge k+1, and the state is STABLE after edge k+2.
- **Lock-fall latency:** same timing as lock rise. Outputs drop 2 edges after the sampling edge.
- **Dwell times:** each state lasts exactly its parameter count in cycles.
- **Best-case bring-up:** `sys_resetn` rises `2+LOCK_STABLE_CYCLES+PHY_RST_CYCLES+PHY_SETTLE_CYCLES` edges after the first edge that samples lock.
- **Glitches:** a lock glitch shorter than one clock may be missed. That is acceptable.
- **Reset release:** `resetn` deassertion is synchronous to `clock` by board design. No reset synchronizer is included in this block.

## Test plan
Use `LOCK_STABLE_CYCLES`=4, `PHY_RST_CYCLES`=8, `PHY_SETTLE_CYCLES`=6, `BLINK_BIT`=2, `LOSS_COUNT_WIDTH`=2.
- **Clean bring-up:** `locked_async`=1 before edge 0 → STABLE at edge 2, `phy_resetn` rises at edge 14, `sys_resetn` and `ready` rise at edge 20, `led` is 0 from edge 20.
- **Early glitch:** lock drops for 3 cycles during STABLE → return to WAIT_LOCK, `loss_count` stays 0, `phy_resetn` never rises, and the sequence restarts with a full STABLE count.
- **Loss in RUN:** lock drops in RUN → 2 edges later `sys_resetn`=0, `phy_resetn`=0, `ready`=0, `loss_count`=1. Lock return repeats the full 18-cycle dwell sequence.
- **Saturation:** 5 lock losses in PHY_SETTLE → `loss_count` reads 1, 2, 3, 3, 3.
- **Simultaneous events:** lock drop on the final PHY_SETTLE dwell cycle → state goes to WAIT_LOCK, never RUN, and `ready` stays 0.
- **Async reset mid-RUN:** pulse `resetn` low between edges → all outputs take their reset values before the next edge, and `loss_count`=0.
